// File: rtl/id_stage_pipelined_if.sv
// rtl/id_stage_pipelined_if.sv - ID stage pipeline-side signal bundle
// master drives the stage inputs (IF/ID, WB, MEM, debug); slave is the decode stage itself.
interface id_stage_pipelined_if #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5
);
  logic                 i_step;
  logic                 i_valid;
  logic [BITS_SIZE-1:0] i_instr;
  logic [BITS_SIZE-1:0] i_ifid_pc4;
  logic                 i_ctl_is_jump;
  logic                 i_ctl_is_jalr;
  logic                 i_ctl_branch;
  logic                 i_ctl_neq_branch;
  logic                 i_ctl_uses_rt;
  logic                 i_ctl_reg_write;
  logic                 i_ctl_mem_read;
  logic [1:0]           i_ctl_ext_mode;
  logic                 i_wb_reg_write;
  logic [BITS_REGS-1:0] i_wb_addr_rd;
  logic [BITS_SIZE-1:0] i_wb_data;
  logic                 i_mem_mem_read;
  logic [BITS_REGS-1:0] i_mem_addr_rd;
  logic [BITS_REGS-1:0] i_debug_addr;
  logic                 o_stall;
  logic                 o_redirect;
  logic [BITS_SIZE-1:0] o_pc_next;
  logic                 o_idex_valid;
  logic [BITS_SIZE-1:0] o_idex_rs;
  logic [BITS_SIZE-1:0] o_idex_rt;
  logic [BITS_SIZE-1:0] o_idex_imm;
  logic [BITS_REGS-1:0] o_idex_addr_rt;
  logic [BITS_REGS-1:0] o_idex_addr_rd;
  logic                 o_idex_reg_write;
  logic                 o_idex_mem_read;
  logic [BITS_SIZE-1:0] o_debug_data;

  modport master (
    output i_step, i_valid, i_instr, i_ifid_pc4,
           i_ctl_is_jump, i_ctl_is_jalr, i_ctl_branch, i_ctl_neq_branch,
           i_ctl_uses_rt, i_ctl_reg_write, i_ctl_mem_read, i_ctl_ext_mode,
           i_wb_reg_write, i_wb_addr_rd, i_wb_data,
           i_mem_mem_read, i_mem_addr_rd, i_debug_addr,
    input  o_stall, o_redirect, o_pc_next, o_idex_valid, o_idex_rs, o_idex_rt,
           o_idex_imm, o_idex_addr_rt, o_idex_addr_rd, o_idex_reg_write,
           o_idex_mem_read, o_debug_data
  );

  modport slave (
    input  i_step, i_valid, i_instr, i_ifid_pc4,
           i_ctl_is_jump, i_ctl_is_jalr, i_ctl_branch, i_ctl_neq_branch,
           i_ctl_uses_rt, i_ctl_reg_write, i_ctl_mem_read, i_ctl_ext_mode,
           i_wb_reg_write, i_wb_addr_rd, i_wb_data,
           i_mem_mem_read, i_mem_addr_rd, i_debug_addr,
    output o_stall, o_redirect, o_pc_next, o_idex_valid, o_idex_rs, o_idex_rt,
           o_idex_imm, o_idex_addr_rt, o_idex_addr_rd, o_idex_reg_write,
           o_idex_mem_read, o_debug_data
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - MIPS decode stage with bypassed register bank and ID/EX bank
// Resolves branches/jumps in ID, stalls on load-use and branch-operand hazards, squashes the wrong-path slot.
module id_stage_pipelined #(
  parameter int BITS_SIZE          = 32,
  parameter int BITS_REGS          = 5,
  parameter int REG_COUNT          = 32,
  parameter int BITS_JUMP          = 26,
  parameter int BITS_INMEDIATE     = 16,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input logic                i_clk,
  input logic                i_reset,
  id_stage_pipelined_if.slave bus
);
  localparam int EXT_PAD = BITS_SIZE - BITS_INMEDIATE;

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t               state_q;
  logic [BITS_SIZE-1:0] regs_q [REG_COUNT];

  logic                 idex_valid_q, idex_valid_d;
  logic [BITS_SIZE-1:0] idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_imm_q, idex_imm_d;
  logic [BITS_REGS-1:0] idex_addr_rt_q, idex_addr_rt_d, idex_addr_rd_q, idex_addr_rd_d;
  logic                 idex_reg_write_q, idex_reg_write_d, idex_mem_read_q, idex_mem_read_d;

  logic [BITS_REGS-1:0]      addr_rs, addr_rt, addr_rd;
  logic [BITS_INMEDIATE-1:0] imm;
  logic [BITS_SIZE-1:0]      rs_val, rt_val, ext, branch_target, jump_target, pc_next;
  logic                      eff_valid, taken, haz_load, haz_branch, stall, redirect, wb_we;
  logic                      unused_opcode;

  assign addr_rs       = bus.i_instr[21 +: BITS_REGS];
  assign addr_rt       = bus.i_instr[16 +: BITS_REGS];
  assign addr_rd       = bus.i_instr[11 +: BITS_REGS];
  assign imm           = bus.i_instr[BITS_INMEDIATE-1:0];
  assign unused_opcode = ^bus.i_instr[BITS_SIZE-1:26];

  // Write-first read: a WB write in the same cycle is visible to ID and debug.
  function automatic logic [BITS_SIZE-1:0] read_reg(input logic [BITS_REGS-1:0] a);
    logic [BITS_SIZE-1:0] r;
    r = '0;
    if (int'(a) >= REG_COUNT || (ZERO_REG_HARDWIRED != 0 && a == '0))
      r = '0;
    else if (bus.i_wb_reg_write && bus.i_wb_addr_rd == a && a != '0)
      r = bus.i_wb_data;
    else
      r = regs_q[a];
    return r;
  endfunction

  function automatic logic result_pending(input logic [BITS_REGS-1:0] a);
    return (a != '0) &&
           ((idex_valid_q && idex_reg_write_q && idex_addr_rd_q == a) ||
            (bus.i_mem_mem_read && bus.i_mem_addr_rd == a));
  endfunction

  always_comb begin
    rs_val = read_reg(addr_rs);
    rt_val = read_reg(addr_rt);
    bus.o_debug_data = read_reg(bus.i_debug_addr);
  end

  always_comb begin
    case (bus.i_ctl_ext_mode)
      2'b00:   ext = {{EXT_PAD{imm[BITS_INMEDIATE-1]}}, imm};
      2'b10:   ext = {{EXT_PAD{1'b0}}, imm} << BITS_INMEDIATE;
      default: ext = {{EXT_PAD{1'b0}}, imm};
    endcase
  end

  assign branch_target = bus.i_ifid_pc4 + (ext << 2);
  assign jump_target   = {bus.i_ifid_pc4[BITS_SIZE-1 -: BITS_SIZE-BITS_JUMP-2],
                          bus.i_instr[BITS_JUMP-1:0], 2'b00};

  assign taken = (bus.i_ctl_branch && rs_val == rt_val) ||
                 (bus.i_ctl_neq_branch && rs_val != rt_val);

  assign eff_valid = bus.i_valid && (state_q == RUN);

  assign haz_load = idex_valid_q && idex_mem_read_q && idex_addr_rt_q != '0 &&
                    (idex_addr_rt_q == addr_rs || (bus.i_ctl_uses_rt && idex_addr_rt_q == addr_rt));

  // Branch compare happens in ID, so any in-flight producer of its operands must drain first.
  assign haz_branch = (bus.i_ctl_branch || bus.i_ctl_neq_branch || bus.i_ctl_is_jalr) &&
                      (result_pending(addr_rs) ||
                       ((bus.i_ctl_branch || bus.i_ctl_neq_branch) && result_pending(addr_rt)));

  assign stall    = eff_valid && (haz_load || haz_branch);
  assign redirect = eff_valid && !stall && (bus.i_ctl_is_jump || bus.i_ctl_is_jalr || taken);

  always_comb begin
    pc_next = '0;
    if (eff_valid) begin
      if (bus.i_ctl_is_jalr)      pc_next = rs_val;
      else if (bus.i_ctl_is_jump) pc_next = jump_target;
      else if (taken)             pc_next = branch_target;
      else                        pc_next = bus.i_ifid_pc4;
    end
  end

  assign bus.o_stall    = stall;
  assign bus.o_redirect = redirect;
  assign bus.o_pc_next  = pc_next;

  assign wb_we = bus.i_step && bus.i_wb_reg_write &&
                 !(ZERO_REG_HARDWIRED != 0 && bus.i_wb_addr_rd == '0) &&
                 int'(bus.i_wb_addr_rd) < REG_COUNT;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[bus.i_wb_addr_rd] <= bus.i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
    end else if (bus.i_step) begin
      case (state_q)
        RUN:     if (redirect) state_q <= SQUASH;
        SQUASH:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    idex_valid_d     = eff_valid && !stall;
    idex_rs_d        = '0;
    idex_rt_d        = '0;
    idex_imm_d       = '0;
    idex_addr_rt_d   = '0;
    idex_addr_rd_d   = '0;
    idex_reg_write_d = 1'b0;
    idex_mem_read_d  = 1'b0;
    if (idex_valid_d) begin
      idex_rs_d        = rs_val;
      idex_rt_d        = rt_val;
      idex_imm_d       = ext;
      idex_addr_rt_d   = addr_rt;
      idex_addr_rd_d   = addr_rd;
      idex_reg_write_d = bus.i_ctl_reg_write;
      idex_mem_read_d  = bus.i_ctl_mem_read;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idex_valid_q     <= 1'b0;
      idex_rs_q        <= '0;
      idex_rt_q        <= '0;
      idex_imm_q       <= '0;
      idex_addr_rt_q   <= '0;
      idex_addr_rd_q   <= '0;
      idex_reg_write_q <= 1'b0;
      idex_mem_read_q  <= 1'b0;
    end else if (bus.i_step) begin
      idex_valid_q     <= idex_valid_d;
      idex_rs_q        <= idex_rs_d;
      idex_rt_q        <= idex_rt_d;
      idex_imm_q       <= idex_imm_d;
      idex_addr_rt_q   <= idex_addr_rt_d;
      idex_addr_rd_q   <= idex_addr_rd_d;
      idex_reg_write_q <= idex_reg_write_d;
      idex_mem_read_q  <= idex_mem_read_d;
    end
  end

  assign bus.o_idex_valid     = idex_valid_q;
  assign bus.o_idex_rs        = idex_rs_q;
  assign bus.o_idex_rt        = idex_rt_q;
  assign bus.o_idex_imm       = idex_imm_q;
  assign bus.o_idex_addr_rt   = idex_addr_rt_q;
  assign bus.o_idex_addr_rd   = idex_addr_rd_q;
  assign bus.o_idex_reg_write = idex_reg_write_q;
  assign bus.o_idex_mem_read  = idex_mem_read_q;
endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised decode stage for the MIPS pipeline.
- Contains a register bank with WB bypass, an immediate extender, and branch/jump resolution in ID.
- Adds load-use and branch-operand hazard detection with stall, a wrong-path squash FSM, and a registered ID/EX output bank.
- Sits between the IF/ID register and EX. All state advances only on i_step (debug single-step).

Parameters:
BITS_SIZE, 32, datapath and PC width
BITS_REGS, 5, register address width
REG_COUNT, 32, number of registers (≤ 2**BITS_REGS)
BITS_JUMP, 26, J-type target field width
BITS_INMEDIATE, 16, immediate field width
ZERO_REG_HARDWIRED, 1, 1 = register 0 reads as 0 and ignores writes

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_step  in  1  advance enable; when 0, no state changes
i_valid  in  1  IF/ID holds a real instruction
i_instr  in  BITS_SIZE  instruction from IF/ID (rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], jump=[25:0])
i_ifid_pc4  in  BITS_SIZE  PC+4 of the instruction
i_ctl_is_jump, i_ctl_is_jalr, i_ctl_branch, i_ctl_neq_branch, i_ctl_uses_rt, i_ctl_reg_write, i_ctl_mem_read  in  1 each  decoded control bits
i_ctl_ext_mode  in  2  00 sign, 01 zero, 10 upper (imm<<16), 11 zero
i_wb_reg_write  in  1  WB write enable
i_wb_addr_rd  in  BITS_REGS  WB destination
i_wb_data  in  BITS_SIZE  WB data
i_mem_mem_read  in  1  load currently in MEM
i_mem_addr_rd  in  BITS_REGS  MEM destination
i_debug_addr  in  BITS_REGS  debug register select
o_stall  out  1  hold PC and IF/ID
o_redirect  out  1  take o_pc_next instead of sequential PC
o_pc_next  out  BITS_SIZE  next PC
o_idex_valid  out  1  ID/EX slot holds a real instruction
o_idex_rs, o_idex_rt, o_idex_imm  out  BITS_SIZE each  registered operands and extended immediate
o_idex_addr_rt, o_idex_addr_rd  out  BITS_REGS each  registered addresses
o_idex_reg_write, o_idex_mem_read  out  1 each  registered control bits
o_debug_data  out  BITS_SIZE  combinational debug read

Behaviour:
- Register bank:
  - Write on the rising edge when i_step & i_wb_reg_write, unless (ZERO_REG_HARDWIRED & addr==0) or addr ≥ REG_COUNT.
  - Reads are combinational. A same-cycle WB write to a matching nonzero address is forwarded to the read (write-first). The debug port also bypasses.
  - Out-of-range reads return 0.
- Extension: per i_ctl_ext_mode, result is BITS_SIZE wide.
- Branch target: pc4 + (ext<<2), modulo 2**BITS_SIZE.
- Jump target: {pc4[top BITS_SIZE-BITS_JUMP-2 bits], jump, 2'b00}.
- Branch taken: (i_ctl_branch & rs==rt) | (i_ctl_neq_branch & rs!=rt). The comparison uses bypassed read data.
- Next-PC priority: jalr (rs) > jump > taken branch > pc4.
- eff_valid = i_valid & (state==RUN).
- o_stall=1 when eff_valid and either hazard holds:
  - (a) o_idex_valid & o_idex_mem_read & o_idex_addr_rt!=0 & (addr_rt==rs | (uses_rt & addr_rt==rt)).
  - (b) the instruction is branch/neq/jalr and it reads a register that is either (o_idex_valid & o_idex_reg_write & o_idex_addr_rd==it, nonzero) or (i_mem_mem_read & i_mem_addr_rd==it, nonzero).
- o_redirect = eff_valid & ~o_stall & (jump|jalr|taken). o_pc_next is valid only when o_redirect is 1.
- FSM (updates only on i_step):
  - RUN→SQUASH on o_redirect.
  - SQUASH→RUN unconditionally after one step.
  - In SQUASH, the IF/ID instruction (wrong path) is discarded: eff_valid=0, no stall, no redirect.
- ID/EX register:
  - On i_step, loads the decoded fields.
  - o_idex_valid <= eff_valid & ~o_stall. A stall inserts a bubble: valid=0 and reg_write=mem_read=0; data fields are don't-care but are cleared to 0.
- Reset (sync, overrides i_step):
  - All registers = 0, state = RUN.
  - All o_idex_* = 0; o_stall=0, o_redirect=0, o_pc_next=0 while i_valid=0.
- i_step=0: outputs hold, no register writes, FSM holds. Combinational outputs still track inputs.
- Latency:
  - Redirect and stall are same-cycle combinational.
  - ID/EX outputs appear one step after acceptance.

Test Plan:
- WB writes r3=0xDEADBEEF while ID reads rs=3 in the same cycle → o_idex_rs=0xDEADBEEF next step. A write to r0 → reads 0.
- o_idex = lw into rt=5; ID = add reading rs=5 → o_stall=1 for one step, bubble (o_idex_valid=0). Next step: no stall, instruction issues.
- beq r1,r2 with r1=r2=7, pc4=0x100, imm=0x0004 → o_redirect=1, o_pc_next=0x110. Following instruction squashed (o_idex_valid=0 one step later), FSM back in RUN.
- bne with o_idex writing r1 (ALU op) → 1-step stall. Then, with the load in MEM writing r1 → second stall. Then resolves.
- jalr rs=r4=0x2000 together with jump=1 → o_pc_next=0x2000. j with pc4=0xF0000004, field 0x0000040 → 0xF0000100.
- Assert i_reset mid-SQUASH while i_step=0 → next edge: state RUN, all registers 0, o_idex_valid=0.
